// File: rtl/mat_mac_array_if.sv
// -----------------------------------------------------------------------------
// mat_mac_array_if
//   Result stream from the 3x3 MAC array to the result consumer.
//   Ports / signals:
//     res_data  [9:0] : C[i][j] (unsigned, or two's complement in the signed build)
//     res_idx   [3:0] : result index 3*i+j, 0..8
//     res_valid       : res_data/res_idx valid
//     res_ready       : consumer accepts the current result
//   Modports:
//     master : producer side (mat_mac_array)
//     slave  : consumer side
// -----------------------------------------------------------------------------
interface mat_mac_array_if;
   logic [9:0] res_data;
   logic [3:0] res_idx;
   logic       res_valid;
   logic       res_ready;

   modport master (
      output res_data,
      output res_idx,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_idx,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/mat_mac_array.sv
// -----------------------------------------------------------------------------
// mat_mac_array
//   Compute stage behind the 3x3 memory bank. Walks the bank through its three
//   unload phases, accumulating the outer product of W column k and X row k
//   into nine accumulators (C = W x X), then streams C row-major to the
//   result consumer over a valid/ready handshake.
//
//   Ports:
//     clk                    : clock, all state on the rising edge
//     clear                  : asynchronous active-high reset
//     start                  : level from the bank, high once W and X are loaded
//     data_outw1..3  [3:0]   : W column k, rows 0..2
//     data_outx1..3  [3:0]   : X row k, columns 0..2
//     unload1..3             : one-hot phase selects to the bank
//     busy                   : high while computing or emitting
//     done                   : high once all nine results are delivered
//     res (master)           : result stream (res_data, res_idx, res_valid, res_ready)
//
//   Build option:
//     MAC_SIGNED_EN : when defined, operands are 4-bit two's complement and the
//                     results are 10-bit two's complement. Interface and timing
//                     are the same in both builds.
// -----------------------------------------------------------------------------
module mat_mac_array (
   input  logic       clk,
   input  logic       clear,
   input  logic       start,
   input  logic [3:0] data_outw1,
   input  logic [3:0] data_outw2,
   input  logic [3:0] data_outw3,
   input  logic [3:0] data_outx1,
   input  logic [3:0] data_outx2,
   input  logic [3:0] data_outx3,
   output logic       unload1,
   output logic       unload2,
   output logic       unload3,
   output logic       busy,
   output logic       done,
   mat_mac_array_if.master res
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_P1,
      S_P2,
      S_P3,
      S_EMIT,
      S_DONE
   } state_t;

   state_t     state;
   logic [3:0] idx;
   logic [9:0] acc [9];
   logic       valid_r;
   logic [3:0] w [3];
   logic [3:0] x [3];

   assign w[0] = data_outw1;
   assign w[1] = data_outw2;
   assign w[2] = data_outw3;
   assign x[0] = data_outx1;
   assign x[1] = data_outx2;
   assign x[2] = data_outx3;

   // Product widened to accumulator width. The sum of three products can never
   // exceed the 10-bit range in either build, so the adder simply wraps modulo
   // 2^10 and still yields the exact result bit pattern.
   function automatic logic [9:0] mac_prod(input logic [3:0] a, input logic [3:0] b);
`ifdef MAC_SIGNED_EN
      logic signed [7:0] ae;
      logic signed [7:0] be;
      logic signed [7:0] p;
      ae = {{4{a[3]}}, a};
      be = {{4{b[3]}}, b};
      p  = ae * be;
      return {{2{p[7]}}, p};
`else
      logic [7:0] p;
      p = {4'b0000, a} * {4'b0000, b};
      return {2'b00, p};
`endif
   endfunction

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state   <= S_IDLE;
         idx     <= 4'd0;
         valid_r <= 1'b0;
         unload1 <= 1'b0;
         unload2 <= 1'b0;
         unload3 <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int k = 0; k < 9; k++) acc[k] <= 10'd0;
      end else begin
         // The bank answers the current unload select combinationally, so the
         // operands on the inputs belong to the phase closing at this edge.
         if (state == S_P1 || state == S_P2 || state == S_P3) begin
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  acc[3*i+j] <= acc[3*i+j] + mac_prod(w[i], x[j]);
               end
            end
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_P1;
                  unload1 <= 1'b1;
                  busy    <= 1'b1;
                  for (int k = 0; k < 9; k++) acc[k] <= 10'd0;
               end
            end
            S_P1: begin
               state   <= S_P2;
               unload1 <= 1'b0;
               unload2 <= 1'b1;
            end
            S_P2: begin
               state   <= S_P3;
               unload2 <= 1'b0;
               unload3 <= 1'b1;
            end
            S_P3: begin
               state   <= S_EMIT;
               unload3 <= 1'b0;
               valid_r <= 1'b1;
            end
            S_EMIT: begin
               if (res.res_ready) begin
                  if (idx == 4'd8) begin
                     state   <= S_DONE;
                     idx     <= 4'd0;
                     valid_r <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            S_DONE: begin
               // Leaving only on a low start keeps a held start from re-running.
               if (!start) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               idx     <= 4'd0;
               valid_r <= 1'b0;
               unload1 <= 1'b0;
               unload2 <= 1'b0;
               unload3 <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Outputs decode only from registered state; res_ready never reaches them.
   assign res.res_valid = valid_r;
   assign res.res_idx   = idx;
   assign res.res_data  = valid_r ? acc[idx] : 10'd0;

endmodule

// File: doc/mat_mac_array.md
# mat_mac_array

- Compute stage directly downstream of the 3x3 memory bank.
- Sequences the bank's three unload phases and accumulates the outer product of each W column and X row into nine accumulators, forming C = W x X.
- Streams the nine results row-major over a valid/ready interface to the result consumer.

## Interface
- No parameters; sizes fixed at 3x3 matrices, 4-bit operands, 10-bit results.
- `clk` in 1: single clock, all state on rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `start` in 1: level from memory bank; high once both matrices are loaded.
- `data_outw1`, `data_outw2`, `data_outw3` in 4 each: W column k, rows 0..2, from the bank.
- `data_outx1`, `data_outx2`, `data_outx3` in 4 each: X row k, columns 0..2, from the bank.
- `unload1`, `unload2`, `unload3` out 1 each: one-hot phase selects to the bank.
- `res_data` out 10: C[i][j].
- `res_idx` out 4: result index 3*i+j, range 0..8.
- `res_valid` out 1: res_data/res_idx valid.
- `res_ready` in 1: consumer accepts.
- `busy` out 1: high in P1, P2, P3 and EMIT.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, P1, P2, P3, EMIT, DONE.
- IDLE → P1 when `start`=1. All nine accumulators are zeroed on this transition.
- Pk (k=1..3): `unloadk`=1, other unloads 0. The bank responds combinationally.
- At the closing edge of Pk, acc[i][j] += w_i * x_j for all nine i,j pairs in parallel.
- P1→P2→P3→EMIT unconditionally, one cycle each.
- EMIT:
  - `res_valid`=1, `res_data`=acc[idx], `res_idx`=idx. idx starts at 0.
  - On `res_valid && res_ready`, idx increments.
  - The transfer at idx=8 moves to DONE and resets idx to 0.
- DONE: `done`=1. Stays in DONE while `start`=1 and returns to IDLE when `start`=0. A `start` held high never re-triggers a computation.
- Arithmetic, unsigned default:
  - Product is 8 bits, max 225.
  - Sum of 3 products, max 675, fits 10 bits with no overflow possible.
  - Operands zero-extended.
- Unloads are 0 outside P1..P3, so the bank drives zeros.
- While `res_valid`=1 and `res_ready`=0, `res_data`/`res_idx` hold stable and idx does not advance.
- `res_ready` is ignored outside EMIT.
- `clear` asserted in any state, including mid-phase or mid-EMIT:
  - State → IDLE, idx → 0, accumulators → 0.
  - Outputs are driven to their reset values immediately, without waiting for a clock edge.
  - The partial result is discarded.

## Timing
- Reset values:
  - `unload1..3`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0.
  - State IDLE, all accumulators 0.
- Cycle numbering: edge 0 samples `start`=1 in IDLE.
  - Cycle 1 = P1, cycle 2 = P2, cycle 3 = P3.
  - Cycle 4: first `res_valid`, carrying C[0][0].
- With `res_ready` held high:
  - Results occupy cycles 4..12, one per cycle.
  - `done` rises in cycle 13; `busy` falls in cycle 13.
- Each stalled cycle (`res_ready`=0 in EMIT) delays `done` by one cycle.
- `done`→IDLE takes one cycle after `start` is sampled low.
- Registered outputs: all outputs decode from state/idx/accumulators only. There is no combinational path from `res_ready` to any output.

## Configuration
- `MAC_SIGNED_EN` defined: operands are 4-bit two's complement (-8..7).
  - Products are signed; accumulators are 10-bit signed, sign-extended.
  - Range -168..192, so no overflow is possible.
  - `res_data` is two's complement.
- `MAC_SIGNED_EN` undefined: unsigned behaviour as above.
- The interface and timing are identical in both builds.

## Test plan
- Identity W, X = 1..9 row-major, `res_ready`=1 → res_idx 0..8 carry 1..9 in cycles 4..12; `done` in cycle 13.
- All operands 15 → all nine results = 675 (0x2A3). Unsigned build: no wrap.
- W = X = 1..9 row-major, `res_ready` low during cycles 5..7 → C[0][1]=36 holds stable through the stall; sequence 30,36,42,66,81,96,102,126,150; `done` in cycle 16.
- `clear` pulsed mid-P2 → all outputs 0 immediately. Restart with identity/1..9 → results correct, with no residue from the aborted run.
- `start` held high after DONE for 10 cycles → no unload pulses and `done` stays 1. Drop `start` → IDLE; raise it again → a fresh run starts.
- `MAC_SIGNED_EN` build, all operands -8 → every result = 192. W all -8, X all 7 → every result = -168 (10'h358).
